// File: rtl/fpu_pkg.sv
// Shared FPU definitions: linear-engine state encoding, accumulator sizing and
// saturation bounds for a signed DATA_W-bit result.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LDX,
    BIAS,
    MACRD,
    WB,
    DONE
  } lfe_state_t;

  // Wide enough for the shifted bias plus MAX_IN full-scale products.
  function automatic int lfe_acc_w(input int data_w, input int max_in);
    return 2 * data_w + $clog2(max_in) + 1;
  endfunction

  function automatic longint sat_hi(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int data_w);
    return -(64'sd1 <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Fixed-point accumulator with bias load and multiply-accumulate, followed by a
// combinational rescale, saturate and optional ReLU stage.
module mac_sat
  import fpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 39
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_load,
  input  logic                     i_mac,
  input  logic                     i_relu,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_y
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(DATA_W));

  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_sh;
  logic signed [2*DATA_W-1:0] w_prod;

  assign w_prod = i_a * i_b;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_acc <= '0;
    else if (i_clear) r_acc <= '0;
    else if (i_load)  r_acc <= ACC_W'(i_a) <<< FRAC_W;
    else if (i_mac)   r_acc <= r_acc + ACC_W'(w_prod);
  end

  assign w_sh = r_acc >>> FRAC_W;

  // NOTE: o_y is assigned on every path before any conditional override, so
  // this block cannot infer a latch.
  always_comb begin
    if (w_sh > SAT_HI)      o_y = SAT_HI[DATA_W-1:0];
    else if (w_sh < SAT_LO) o_y = SAT_LO[DATA_W-1:0];
    else                    o_y = w_sh[DATA_W-1:0];
    if (i_relu && o_y[DATA_W-1]) o_y = '0;
  end

endmodule

// File: rtl/linear_fw_engine.sv
// Linear-layer engine y = act(W*x + b) with runtime n_out x n_in, one shared
// read port, one write port and a local x buffer.
module linear_fw_engine
  import fpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int MAX_IN  = 64,
  parameter int MAX_OUT = 64,
  parameter int ADDR_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             go,
  input  logic [$clog2(MAX_IN+1)-1:0]      n_in,
  input  logic [$clog2(MAX_OUT+1)-1:0]     n_out,
  input  logic                             relu,
  input  logic [ADDR_W-1:0]                x_base,
  input  logic [ADDR_W-1:0]                w_base,
  input  logic [ADDR_W-1:0]                b_base,
  input  logic [ADDR_W-1:0]                y_base,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             rd_req,
  output logic [ADDR_W-1:0]                rd_addr,
  input  logic                             rd_done,
  input  logic [DATA_W-1:0]                rd_data,
  output logic                             wr_req,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [DATA_W-1:0]                wr_data,
  input  logic                             wr_done
);

  localparam int IN_W  = $clog2(MAX_IN + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int XI_W  = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
  localparam int ACC_W = lfe_acc_w(DATA_W, MAX_IN);

  lfe_state_t         r_state, w_next;
  logic               r_bub;
  logic               r_err;
  logic [IN_W-1:0]    r_j;
  logic [OUT_W-1:0]   r_i;
  logic [ADDR_W-1:0]  r_w_ptr;
  logic [DATA_W-1:0]  r_rdata;
  logic [DATA_W-1:0]  r_xbuf [MAX_IN];

  logic               w_ok, w_xfer, w_last_j, w_last_i;
  logic [DATA_W-1:0]  w_y;

  assign w_ok     = (n_in != '0) && (n_in <= IN_W'(MAX_IN)) &&
                    (n_out != '0) && (n_out <= OUT_W'(MAX_OUT));
  assign w_xfer   = (rd_req & rd_done) | (wr_req & wr_done);
  assign w_last_j = (r_j == n_in - IN_W'(1));
  assign w_last_i = (r_i == n_out - OUT_W'(1));

  assign busy = (r_state != IDLE) && (r_state != DONE);
  assign done = (r_state == DONE);
  assign err  = done & r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // r_bub marks the one-cycle bubble after each handshake; all index and
  // state updates happen in that cycle, so requests keep stable addresses.
  always_comb begin
    w_next  = r_state;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    case (r_state)
      IDLE:  if (go) w_next = w_ok ? LDX : DONE;
      LDX: begin
        rd_req  = !r_bub;
        rd_addr = x_base + ADDR_W'(r_j);
        if (r_bub && w_last_j) w_next = BIAS;
      end
      BIAS: begin
        rd_req  = !r_bub;
        rd_addr = b_base + ADDR_W'(r_i);
        if (r_bub) w_next = MACRD;
      end
      MACRD: begin
        rd_req  = !r_bub;
        rd_addr = r_w_ptr;
        if (r_bub && w_last_j) w_next = WB;
      end
      WB: begin
        wr_req  = !r_bub;
        wr_addr = y_base + ADDR_W'(r_i);
        wr_data = w_y;
        if (r_bub) w_next = w_last_i ? DONE : BIAS;
      end
      DONE:    if (!go) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bub   <= 1'b0;
      r_err   <= 1'b0;
      r_j     <= '0;
      r_i     <= '0;
      r_w_ptr <= '0;
      r_rdata <= '0;
    end else begin
      r_bub <= w_xfer;
      if (rd_req && rd_done) r_rdata <= rd_data;
      case (r_state)
        IDLE: if (go) begin
          r_j   <= '0;
          r_i   <= '0;
          r_err <= !w_ok;
        end
        LDX: if (r_bub) begin
          r_j <= w_last_j ? '0 : r_j + IN_W'(1);
          if (w_last_j) r_w_ptr <= w_base;
        end
        MACRD: if (r_bub) begin
          r_j     <= w_last_j ? '0 : r_j + IN_W'(1);
          r_w_ptr <= r_w_ptr + ADDR_W'(1);
        end
        WB: if (r_bub) r_i <= r_i + OUT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the x buffer is a storage array with no reset; every entry a job
  // reads is written in LDX of that same job before use.
  always_ff @(posedge clk) begin
    if (r_state == LDX && r_bub) r_xbuf[r_j[XI_W-1:0]] <= r_rdata;
  end

  mac_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == IDLE && go),
    .i_load  (r_state == BIAS && r_bub),
    .i_mac   (r_state == MACRD && r_bub),
    .i_relu  (relu),
    .i_a     (r_rdata),
    .i_b     (r_xbuf[r_j[XI_W-1:0]]),
    .o_y     (w_y)
  );

endmodule

// File: tb/tb_linear_fw_engine.sv
// Scoreboard bench: jobs push expected reads/writes from an arithmetic model;
// a monitor pops and compares on every completed handshake.
module tb_linear_fw_engine;

  localparam int DATA_W = 16, FRAC_W = 8, MAX_IN = 64, MAX_OUT = 64, ADDR_W = 16;
  localparam int IN_W = $clog2(MAX_IN + 1), OUT_W = $clog2(MAX_OUT + 1);

  logic clk, rst, go, relu;
  logic [IN_W-1:0] n_in;
  logic [OUT_W-1:0] n_out;
  logic [15:0] x_base, w_base, b_base, y_base;
  logic busy, done, err, rd_req, rd_done, wr_req, wr_done;
  logic [15:0] rd_addr, rd_data, wr_addr, wr_data;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem [0:65535];
  int n_checks = 0, n_errors = 0, n_req = 0, n_rd = 0, req0 = 0, k_lat = 1;
  bit cur_valid;

  linear_fw_engine #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .MAX_IN(MAX_IN),
                     .MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .go(go), .n_in(n_in), .n_out(n_out), .relu(relu),
    .x_base(x_base), .w_base(w_base), .b_base(b_base), .y_base(y_base),
    .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // y[i] straight from the definition: bias scaled to Q format, dot product,
  // rescale, clamp to the 16-bit signed range, optional ReLU.
  function automatic logic [15:0] model_y(input int ni, input logic [15:0] xb, wb, bb,
                                          input int i, input bit rl);
    longint acc, y;
    acc = longint'($signed(mem[16'(bb + i)])) * (longint'(1) << FRAC_W);
    for (int j = 0; j < ni; j++)
      acc += longint'($signed(mem[16'(xb + j)])) * longint'($signed(mem[16'(wb + i * ni + j)]));
    y = acc >>> FRAC_W;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    if (rl && y < 0) y = 0;
    return 16'(y);
  endfunction

  // Memory model: each request is answered k_lat cycles after it rises.
  initial begin
    int cnt;
    cnt = 0; rd_done = 1'b0; wr_done = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst || rd_done || wr_done) begin
        rd_done = 1'b0; wr_done = 1'b0; cnt = 0;
      end else if (rd_req || wr_req) begin
        if (cnt >= k_lat) begin
          if (rd_req) begin rd_done = 1'b1; rd_data = mem[rd_addr]; end
          else begin wr_done = 1'b1; mem[wr_addr] = wr_data; end
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitor: compares every completed handshake against the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (rd_req || wr_req) n_req++;
        if (rd_req && rd_done) begin
          n_rd++;
          check("rd_wr_exclusive", wr_req, 0);
          if (exp_rd.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_read: addr %0h with none expected", rd_addr);
          end else check("rd_addr", rd_addr, exp_rd.pop_front());
        end
        if (wr_req && wr_done) begin
          check("rd_wr_exclusive", rd_req, 0);
          if (exp_wr.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_write: addr %0h data %0h with none expected", wr_addr, wr_data);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
        end
      end
    end
  end

  task automatic start_job(input int ni, no, input bit rl, input logic [15:0] xb, wb, bb, yb);
    wr_t w;
    cur_valid = ni >= 1 && ni <= MAX_IN && no >= 1 && no <= MAX_OUT;
    if (cur_valid) begin
      for (int j = 0; j < ni; j++) exp_rd.push_back(16'(xb + j));
      for (int i = 0; i < no; i++) begin
        exp_rd.push_back(16'(bb + i));
        for (int j = 0; j < ni; j++) exp_rd.push_back(16'(wb + i * ni + j));
        w.addr = 16'(yb + i);
        w.data = model_y(ni, xb, wb, bb, i, rl);
        exp_wr.push_back(w);
      end
    end
    @(negedge clk);
    n_in = IN_W'(ni); n_out = OUT_W'(no); relu = rl;
    x_base = xb; w_base = wb; b_base = bb; y_base = yb;
    req0 = n_req;
    go = 1'b1;
  endtask

  task automatic finish_job(input int ni, no, input bit hold);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done && !hold && cyc == 2) go = 1'b0;
    end while (!done && cyc < 20000);
    check("done_seen", done, 1);
    if (cur_valid && k_lat == 1) check("done_latency", cyc, 3 * (ni + no * (ni + 2)) + 1);
    if (!cur_valid) check("err_latency", cyc, 1);
    check("err", err, !cur_valid);
    check("reads_left", exp_rd.size(), 0);
    check("writes_left", exp_wr.size(), 0);
    go = 1'b0;
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    if (!cur_valid) check("err_no_traffic", n_req - req0, 0);
  endtask

  task automatic run_job(input int ni, no, input bit rl, input logic [15:0] xb, wb, bb, yb,
                         input bit hold);
    start_job(ni, no, rl, xb, wb, bb, yb);
    finish_job(ni, no, hold);
  endtask

  task automatic one_by_one(input logic [15:0] x, w, b, input bit rl, input logic [15:0] exp_y,
                            input string name);
    mem[16'h0010] = x; mem[16'h0100] = w; mem[16'h0200] = b; mem[16'h0300] = 16'hDEAD;
    run_job(1, 1, rl, 16'h0010, 16'h0100, 16'h0200, 16'h0300, 1);
    check(name, mem[16'h0300], exp_y);
  endtask

  initial begin
    logic [15:0] xb, wb, bb, yb;
    int ni, no;
    rst = 1'b1; go = 1'b0; relu = 1'b0; n_in = '0; n_out = '0;
    x_base = '0; w_base = '0; b_base = '0; y_base = '0;
    #2;
    check("rst_busy", busy, 0);    check("rst_done", done, 0);
    check("rst_err", err, 0);      check("rst_rd_req", rd_req, 0);
    check("rst_wr_req", wr_req, 0); check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0); check("rst_wr_data", wr_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", busy, 0);

    // Basic job
    mem[16'h0010] = 16'h0100; mem[16'h0011] = 16'h0200;
    mem[16'h0100] = 16'h0080; mem[16'h0101] = 16'h0040;
    mem[16'h0200] = 16'h0100; mem[16'h0300] = 16'hDEAD;
    run_job(2, 1, 0, 16'h0010, 16'h0100, 16'h0200, 16'h0300, 1);
    check("basic_y", mem[16'h0300], 16'h0200);

    // Saturation and ReLU
    one_by_one(16'h7F00, 16'h7F00, 16'h7FFF, 0, 16'h7FFF, "sat_pos");
    one_by_one(16'h8100, 16'h8100, 16'h7FFF, 0, 16'h7FFF, "sat_negneg");
    one_by_one(16'h7F00, 16'h8100, 16'h7FFF, 0, 16'h8000, "sat_neg");
    one_by_one(16'h0100, 16'hFF00, 16'h0000, 0, 16'hFF00, "relu_off");
    one_by_one(16'h0100, 16'hFF00, 16'h0000, 1, 16'h0000, "relu_on");

    // Multi-row: identity weights, row 3 all zero
    mem[16'h0020] = 16'h0005; mem[16'h0021] = 16'h0200; mem[16'h0022] = 16'hFF00;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) mem[16'(16'h0400 + i * 3 + j)] = (i == j) ? 16'h0100 : 16'h0000;
      mem[16'(16'h0500 + i)] = 16'(i + 1);
      mem[16'(16'h0600 + i)] = 16'hDEAD;
    end
    run_job(3, 4, 0, 16'h0020, 16'h0400, 16'h0500, 16'h0600, 1);
    check("multi_y0", mem[16'h0600], 16'h0006);
    check("multi_y1", mem[16'h0601], 16'h0202);
    check("multi_y2", mem[16'h0602], 16'hFF03);
    check("multi_y3", mem[16'h0603], 16'h0004);

    // Rejected shapes
    run_job(0, 1, 0, 16'h0020, 16'h0400, 16'h0500, 16'h0600, 1);
    run_job(1, MAX_OUT + 1, 0, 16'h0020, 16'h0400, 16'h0500, 16'h0600, 1);

    // Reset while a weight read is pending, then a job with fresh x values
    start_job(3, 4, 0, 16'h0020, 16'h0400, 16'h0500, 16'h0600);
    begin
      int rd_start, cyc;
      rd_start = n_rd - 0; cyc = 0;
      rd_start = n_rd;
      do begin @(negedge clk); #2; cyc++; end
      while (!((n_rd - rd_start) >= 4 && rd_req) && cyc < 200);
      check("macrd_reached", rd_req, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_rd_req", rd_req, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      exp_rd.delete(); exp_wr.delete(); go = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
    end
    mem[16'h0020] = 16'h0300; mem[16'h0021] = 16'hFE00; mem[16'h0022] = 16'h0011;
    run_job(3, 4, 0, 16'h0020, 16'h0400, 16'h0500, 16'h0600, 1);
    check("reload_y0", mem[16'h0600], 16'h0301);
    check("reload_y1", mem[16'h0601], 16'hFE02);

    // Randomised jobs: shapes, latency, relu, go drop and address wrap
    for (int t = 0; t < 26; t++) begin
      ni = (t == 0) ? MAX_IN : $urandom_range(1, 8);
      no = (t == 1) ? MAX_OUT : $urandom_range(1, 6);
      k_lat = $urandom_range(1, 3);
      xb = 16'hFFF0 + 16'($urandom_range(0, 15));
      wb = 16'h1000 + 16'($urandom_range(0, 255));
      bb = 16'h3000 + 16'($urandom_range(0, 255));
      yb = 16'h4000 + 16'($urandom_range(0, 255));
      for (int j = 0; j < ni; j++)
        mem[16'(xb + j)] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      for (int k = 0; k < ni * no; k++)
        mem[16'(wb + k)] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      for (int i = 0; i < no; i++) mem[16'(bb + i)] = 16'($urandom);
      run_job(ni, no, 1'($urandom_range(0, 1)), xb, wb, bb, yb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/linear_fw_engine.md
# linear_fw_engine

Parametrised fixed-point linear-layer engine for the FPU: computes y = act(W·x + b) for a job of runtime size n_out × n_in, up to MAX_OUT × MAX_IN.
- Sits under the FPU job manager. It is the successor to the fixed single-shape linear-forward FSM.
- Adds runtime dimensions, configurable data width and fraction bits, saturation, an optional ReLU, error reporting and a local input buffer.
- Uses one shared read port and one write port toward the memory handles.

## Interface
Parameters:
- DATA_W, 16, signed two's-complement word width for x, W, b and y.
- FRAC_W, 8, fraction bits of the Q format, 0 ≤ FRAC_W < DATA_W.
- MAX_IN, 64, maximum n_in; sets the depth of the local x buffer.
- MAX_OUT, 64, maximum n_out.
- ADDR_W, 16, memory word-address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- go  in  1  job request (level), sampled in IDLE.
- n_in  in  $clog2(MAX_IN+1)  input length, stable while busy.
- n_out  in  $clog2(MAX_OUT+1)  output length, stable while busy.
- relu  in  1  1 = clamp negative results to 0.
- x_base, w_base, b_base, y_base  in  ADDR_W each  region base addresses.
- busy  out  1  engine is not in IDLE or DONE.
- done  out  1  job finished; held until go = 0.
- err  out  1  job rejected; valid while done = 1.
- rd_req  out  1  read request.
- rd_addr  out  ADDR_W  read address.
- rd_done  in  1  read data valid this cycle.
- rd_data  in  DATA_W  read data.
- wr_req  out  1  write request.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- wr_done  in  1  write accepted this cycle.

## Operation
- States: IDLE, LDX, BIAS, MACRD, WB, DONE.
- IDLE → LDX on go if 1 ≤ n_in ≤ MAX_IN and 1 ≤ n_out ≤ MAX_OUT.
  - Otherwise IDLE → DONE with err = 1 and no memory traffic.
- LDX: reads x[j] at x_base+j for j = 0..n_in−1 into the x buffer, then → BIAS with row i = 0.
- BIAS: reads b[i] at b_base+i; acc = sign-extended b[i] << FRAC_W; → MACRD.
- MACRD: reads W[i][j] at w_base + i·n_in + j; acc += W[i][j]·xbuf[j]; after j = n_in−1 → WB.
- WB: writes y[i] to y_base+i.
  - y[i] = sat(acc >>> FRAC_W); the shift is arithmetic.
  - If relu = 1 and the result is negative, y[i] = 0.
  - Then i+1 → BIAS, or after the last row → DONE.
- DONE: done = 1; → IDLE when go = 0.
- Arithmetic:
  - Product is 2·DATA_W bits.
  - acc is ACC_W = 2·DATA_W + $clog2(MAX_IN)+1 bits; it never wraps.
  - sat clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Address arithmetic is modulo 2^ADDR_W.

## Timing
- Reset values: busy = 0, done = 0, err = 0, rd_req = 0, wr_req = 0; rd_addr, wr_addr and wr_data are all 0.
- Reset clears the state to IDLE and takes effect immediately, including mid-job.
- After reset the engine does not start a job until go is sampled high in IDLE.
- Read/write transaction:
  - The request is driven high with stable address (and data, for writes) starting in cycle t.
  - The request holds until the cycle t+k in which *_done = 1; data is captured in that cycle.
  - The request is low in cycle t+k+1 (mandatory bubble; the accumulate/state update occurs here).
  - The next request may rise in cycle t+k+2.
- *_done while the matching request is low is ignored.
- rd_req and wr_req are never high together.
- First request: the cycle after go is sampled in IDLE.
- done rises the cycle after the final write's bubble.
- With k = 1, go-sampled to done = 3·(n_in + n_out·(n_in+2)) + 1 cycles.
- Error path: done and err are high the cycle after go is sampled.
- go dropped mid-job is ignored; the job completes.

## Structure
- Shared package fpu_pkg:
  - lfe_state_t enum.
  - ACC_W function of DATA_W/MAX_IN.
  - The saturation-bound constants.
- Sub-module mac_sat, which provides:
  - A registered accumulator with load-bias, multiply-accumulate and clear controls.
  - The combinational output of shift, saturate and optional ReLU.
- The x buffer is a MAX_IN×DATA_W register array, written only in LDX.

## Test plan
All scenarios use DATA_W = 16 and FRAC_W = 8, with the memory model at k = 1.
- Basic job:
  - Stimulus: n_in = 2, n_out = 1, x = [0x0100, 0x0200], W = [0x0080, 0x0040], b = 0x0100.
  - Response: exactly one write, y[0] = 0x0200 at y_base; done at cycle 3·(2+4)+1 = 19.
- Saturation:
  - Stimulus: x = [0x7F00], W = [0x7F00], b = 0x7FFF.
  - Response: y = 0x7FFF; with both inputs 0x8100, y = 0x7FFF; with W = 0x8100, y = 0x8000.
- ReLU:
  - Stimulus: x = [0x0100], W = [0xFF00], b = 0.
  - Response: relu = 0 gives y = 0xFF00; relu = 1 gives y = 0x0000.
- Multi-row:
  - Stimulus: n_in = 3, n_out = 4, W = identity·0x0100, b = [1, 2, 3, 4].
  - Response: row i equals x[i] + b[i] for i < 3 and b[3] for row 3.
  - Response: write addresses are y_base..y_base+3 and weight read addresses are row-major.
- Error:
  - Stimulus: n_in = 0, then separately n_out = MAX_OUT+1.
  - Response: done = 1 and err = 1 the next cycle, with zero rd_req/wr_req; dropping go returns the engine to IDLE.
- Reset mid-job:
  - Stimulus: assert rst while rd_req = 1 in MACRD.
  - Response: rd_req, busy and done go to 0 without waiting for a clock edge.
  - Response: a following job produces correct results, and the x buffer is reloaded.
